// File: rtl/inst_loader.sv
// Switch-driven instruction loader: the operator keys in up to 32 words, then
// runs them on a processor that fetches by pc and is held in reset otherwise.
module inst_loader (
  input  logic       clk1Hz,
  input  logic       clr,
  input  logic [7:0] sw,
  input  logic       load_btn,
  input  logic       run_btn,
  input  logic [7:0] pc,
  output logic [7:0] inst,
  output logic       proc_hold,
  output logic [5:0] wcount,
  output logic       full,
  output logic       done
);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    HALT
  } state_t;

  state_t     state;
  logic [7:0] mem [32];
  logic       load_prev;
  logic       run_prev;
  logic       load_edge;
  logic       run_edge;
  logic [7:0] wcount_ext;
  logic       pc_valid;

  // Prev registers reset high so a button held through clr makes no edge.
  assign load_edge  = load_btn & ~load_prev;
  assign run_edge   = run_btn & ~run_prev;
  assign wcount_ext = {2'b00, wcount};
  assign pc_valid   = (pc < wcount_ext);

  always_ff @(posedge clk1Hz or posedge clr) begin
    if (clr) begin
      state     <= LOAD;
      proc_hold <= 1'b1;
      wcount    <= 6'd0;
      load_prev <= 1'b1;
      run_prev  <= 1'b1;
      for (int i = 0; i < 32; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      load_prev <= load_btn;
      run_prev  <= run_btn;
      unique case (state)
        LOAD: begin
          // A load edge always wins over a simultaneous run edge.
          if (load_edge) begin
            if (wcount < 6'd32) begin
              mem[wcount[4:0]] <= sw;
              wcount           <= wcount + 6'd1;
            end
          end else if (run_edge && (wcount != 6'd0)) begin
            state     <= RUN;
            proc_hold <= 1'b0;
          end
        end
        RUN: begin
          if (!pc_valid) begin
            state     <= HALT;
            proc_hold <= 1'b1;
          end
        end
        HALT: begin
          // Reloading keeps old words; they are simply overwritten as loaded.
          if (load_edge) begin
            state  <= LOAD;
            wcount <= 6'd0;
          end else if (run_edge) begin
            state     <= RUN;
            proc_hold <= 1'b0;
          end
        end
        default: begin
          state     <= LOAD;
          proc_hold <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    inst = 8'h00;
    if ((state == RUN) && pc_valid) begin
      inst = mem[pc[4:0]];
    end
  end

  assign full = (wcount == 6'd32);
  assign done = (state == HALT);

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have clock clk1Hz; all state updates occur on its rising edge.
REQ-002 SHALL have reset clr, asynchronous, active-high.
REQ-003 SHALL have clk1Hz  input  1  system clock (processor-rate tick).
REQ-004 SHALL have clr  input  1  asynchronous active-high reset.
REQ-005 SHALL have sw  input  8  instruction word entered on switches.
REQ-006 SHALL have load_btn  input  1  level button; each rising edge stores sw.
REQ-007 SHALL have run_btn  input  1  level button; rising edge starts execution.
REQ-008 SHALL have pc  input  8  processor program counter (fetch address).
REQ-009 SHALL have inst  output  8  instruction supplied to processor, combinational from pc and state.
REQ-010 SHALL have proc_hold  output  1  holds processor in reset while 1 (drives processor clr together with system clr).
REQ-011 SHALL have wcount  output  6  number of words loaded, 0..32.
REQ-012 SHALL have full  output  1  wcount == 32.
REQ-013 SHALL have done  output  1  state == HALT.

Function
REQ-014 SHALL contain 32 x 8-bit instruction storage, written only in LOAD, indexed by wcount[4:0].
REQ-015 SHALL detect button edges as btn & ~btn_prev, btn_prev registered per button each cycle.
REQ-016 SHALL implement states LOAD, RUN, HALT.
REQ-017 LOAD: load edge with wcount < 32 -> mem[wcount] <= sw, wcount <= wcount+1 (write visible next cycle).
REQ-018 LOAD: load edge with wcount == 32 -> no write, wcount unchanged (no wrap).
REQ-019 LOAD: run edge with wcount > 0 and no simultaneous load edge -> RUN; run edge with wcount == 0 -> ignored.
REQ-020 LOAD: simultaneous load and run edges -> load action only, run edge discarded.
REQ-021 proc_hold SHALL be 1 in LOAD and HALT, 0 in RUN (registered with state).
REQ-022 RUN: inst = mem[pc[4:0]] when pc < wcount (unsigned 8-bit compare), else 8'h00.
REQ-023 RUN: pc >= wcount sampled at rising edge -> HALT next cycle.
REQ-024 LOAD and HALT: inst SHALL be 8'h00.
REQ-025 HALT: load edge -> LOAD with wcount <= 0 (old contents retained until overwritten); run edge -> RUN (rerun same program, processor restarted from pc 0 by the one-or-more-cycle proc_hold); simultaneous -> load wins.
REQ-026 RUN: button edges SHALL be ignored.
REQ-027 full and done SHALL be combinational decodes of wcount and state.

Reset
REQ-028 On clr: state <= LOAD, wcount <= 0, all 32 words <= 8'h00, both btn_prev <= 1 (a button held through reset creates no edge).
REQ-029 Reset values: inst = 8'h00, proc_hold = 1, wcount = 0, full = 0, done = 0.
REQ-030 clr asserted mid-RUN or mid-LOAD SHALL abort immediately to the REQ-028 state regardless of clk1Hz.

Verification
REQ-031 Reset, pulse load with sw=8'h61 then 8'h15, pulse run, drive pc=0,1 -> inst=8'h61, 8'h15; proc_hold=0; pc=2 -> inst=8'h00, done=1 next cycle.
REQ-032 Reset, run pulse with no loads -> state stays LOAD, proc_hold=1, wcount=0.
REQ-033 33 load pulses with sw=index -> wcount=32, full=1, mem[31]=8'd31, 33rd value not stored.
REQ-034 Load and run rising in same cycle after one prior load -> wcount=2, state LOAD; next lone run edge -> RUN.
REQ-035 In RUN with pc=1, assert clr asynchronously between clock edges -> proc_hold=1, wcount=0, inst=8'h00 immediately.
REQ-036 HALT after 3-word program, run pulse -> RUN, pc=0 yields original word 0; load pulse from HALT -> LOAD, wcount=0.
